// File: rtl/can_tx_queue.sv
// Transmit queue in front of can_controller: FIFO plus tx_start/tx_ready handshake.
// Optional REQ timeout abort enabled by defining CAN_TXQ_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no frame in flight; request when head present and controller idle
//   REQ   | tx_start high, waiting for controller to go busy
//   BUSY  | controller transmitting head; pop on tx_ready rising back to 1
module can_tx_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
`ifdef CAN_TXQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 65535
`endif
) (
    input  logic                     GCLK,
    input  logic                     RES,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [WIDTH-1:0]         DIN,
    output logic                     tx_start,
    input  logic                     tx_ready,
    output logic                     sent
`ifdef CAN_TXQ_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               push, pop, load, start_nxt, sent_nxt;
    logic [LW-1:0]      level_nxt;

`ifdef CAN_TXQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      to_cnt;
    logic               to_hit;
`endif

    always_ff @(posedge GCLK or negedge RES) begin
        if (!RES) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_nxt = tx_start;
        load      = 1'b0;
        pop       = 1'b0;
        sent_nxt  = 1'b0;
`ifdef CAN_TXQ_TIMEOUT_EN
        to_hit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                start_nxt = 1'b0;
                if (!empty && tx_ready) begin
                    load      = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!tx_ready) begin
                    start_nxt = 1'b0;
                    state_nxt = BUSY;
                end
`ifdef CAN_TXQ_TIMEOUT_EN
                // controller never accepted: drop the head without transmitting
                else if (to_cnt == '0) begin
                    to_hit    = 1'b1;
                    pop       = 1'b1;
                    start_nxt = 1'b0;
                    state_nxt = IDLE;
                end
`endif
            end
            BUSY: begin
                start_nxt = 1'b0;
                if (tx_ready) begin
                    pop       = 1'b1;
                    sent_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                start_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // a pop frees the slot in the same cycle, so a write while full is still taken
    assign push      = wr_en && (!full || pop);
    assign level_nxt = level + LW'(push) - LW'(pop);

    always_ff @(posedge GCLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge GCLK or negedge RES) begin
        if (!RES) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            DIN      <= '0;
            tx_start <= 1'b0;
            sent     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level    <= level_nxt;
            full     <= (level_nxt == LW'(DEPTH));
            empty    <= (level_nxt == '0);
            if (wr_en && full && !pop) overflow <= 1'b1;
            if (load) DIN <= mem[rd_ptr];
            tx_start <= start_nxt;
            sent     <= sent_nxt;
        end
    end

`ifdef CAN_TXQ_TIMEOUT_EN
    always_ff @(posedge GCLK or negedge RES) begin
        if (!RES) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_hit;
            if (load)
                to_cnt <= TW'(TIMEOUT - 1);
            else if (state == REQ && to_cnt != '0)
                to_cnt <= to_cnt - TW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_can_tx_queue.sv
// Bench for can_tx_queue: queue-based reference model with a scripted/random controller.
// Define CAN_TXQ_TIMEOUT_EN to also exercise the REQ timeout path.
module tb_can_tx_queue;

    localparam int DEPTH  = 8;
    localparam int TO_CYC = 20;

    logic        GCLK, RES, wr_en, tx_ready;
    logic [31:0] wr_data, DIN;
    logic        full, empty, overflow, tx_start, sent;
    logic [3:0]  level;
`ifdef CAN_TXQ_TIMEOUT_EN
    logic        timeout_err;
`endif

    can_tx_queue #(
        .WIDTH(32), .DEPTH(DEPTH)
`ifdef CAN_TXQ_TIMEOUT_EN
        , .TIMEOUT(TO_CYC)
`endif
    ) dut (
        .GCLK(GCLK), .RES(RES), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .DIN(DIN), .tx_start(tx_start), .tx_ready(tx_ready), .sent(sent)
`ifdef CAN_TXQ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    initial GCLK = 1'b0;
    always #5 GCLK = ~GCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: queue contents plus the frame the controller is handling
    logic [31:0] m_q[$];
    int          m_phase;      // 0 no frame, 1 requested, 2 controller busy
    int          m_req_cyc;
    logic [31:0] exp_din;
    logic        exp_start, exp_sent, exp_ovf, exp_terr;

    // controller behaviour
    int  c_phase, c_cnt, acc_dly, busy_len;
    bit  hold, wr_on_pop;

    // observations
    int          cyc, n_sent, n_terr, last_sent_cyc, gap;
    bit          prev_start;
    logic [31:0] last_din;

    task automatic ctrl_tick();
        case (c_phase)
            0: begin
                tx_ready = !hold;
                if (tx_start && !hold) begin
                    c_cnt   = acc_dly;
                    c_phase = 1;
                end
            end
            1: if (c_cnt == 0) begin
                tx_ready = 1'b0;
                c_cnt    = busy_len;
                c_phase  = 2;
            end else c_cnt--;
            default: if (c_cnt == 0) begin
                tx_ready = 1'b1;
                c_phase  = 0;
            end else c_cnt--;
        endcase
    endtask

    task automatic step(input bit wr, input logic [31:0] d);
        int sz;
        bit pop_s, pop_t, acc;
        ctrl_tick();
        if (wr_on_pop && m_phase == 2 && tx_ready) begin
            wr = 1'b1;
            d  = 32'hA;
            wr_on_pop = 1'b0;
        end
        wr_en   = wr;
        wr_data = d;
        @(posedge GCLK);
        cyc++;
        sz    = m_q.size();
        pop_s = (m_phase == 2) && tx_ready;
        pop_t = 1'b0;
`ifdef CAN_TXQ_TIMEOUT_EN
        pop_t = (m_phase == 1) && tx_ready && (m_req_cyc + 1 == TO_CYC);
`endif
        acc      = wr_en && (sz < DEPTH || pop_s || pop_t);
        exp_sent = pop_s;
        exp_terr = pop_t;
        if (wr_en && !acc) exp_ovf = 1'b1;
        case (m_phase)
            0: if (sz != 0 && tx_ready) begin
                exp_din   = m_q[0];
                exp_start = 1'b1;
                m_phase   = 1;
                m_req_cyc = 0;
            end
            1: if (!tx_ready) begin
                exp_start = 1'b0;
                m_phase   = 2;
            end else begin
                m_req_cyc++;
                if (pop_t) begin
                    exp_start = 1'b0;
                    m_phase   = 0;
                end
            end
            default: if (tx_ready) m_phase = 0;
        endcase
        if (pop_s || pop_t) void'(m_q.pop_front());
        if (acc) m_q.push_back(wr_data);
        #1;
        check("level", level, m_q.size());
        check("full", full, m_q.size() == DEPTH);
        check("empty", empty, m_q.size() == 0);
        check("overflow", overflow, exp_ovf);
        check("tx_start", tx_start, exp_start);
        check("sent", sent, exp_sent);
        check("din", DIN, exp_din);
`ifdef CAN_TXQ_TIMEOUT_EN
        check("timeout_err", timeout_err, exp_terr);
        if (timeout_err) n_terr++;
`endif
        if (sent) begin
            n_sent++;
            last_sent_cyc = cyc;
        end
        if (tx_start && !prev_start) begin
            last_din = DIN;
            gap      = cyc - last_sent_cyc;
        end
        prev_start = tx_start;
        wr_en = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic do_reset();
        RES = 1'b0;
        #1;
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_level", level, 4'd0);
        check("rst_din", DIN, 32'h0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_sent", sent, 1'b0);
        m_q.delete();
        m_phase = 0; m_req_cyc = 0;
        exp_din = '0; exp_start = 0; exp_sent = 0; exp_ovf = 0; exp_terr = 0;
        c_phase = 0; c_cnt = 0; hold = 0; wr_on_pop = 0;
        tx_ready = 1'b1; wr_en = 1'b0; prev_start = 0;
        @(posedge GCLK);
        #1;
        RES = 1'b1;
    endtask

    initial begin
        int base;
        RES = 1'b1; wr_en = 1'b0; wr_data = '0; tx_ready = 1'b1;
        cyc = 0; n_sent = 0; n_terr = 0; last_sent_cyc = -100; gap = 0;
        @(posedge GCLK);
        #1;
        do_reset();

        // single frame, slow controller
        acc_dly = 3; busy_len = 200; base = n_sent;
        step(1'b1, 32'h4849);
        idle_steps(240);
        check("t1_sent_count", n_sent - base, 1);
        check("t1_din", last_din, 32'h4849);

        // fill with controller held off, overflow on the ninth
        hold = 1; base = n_sent;
        for (int i = 1; i <= 9; i++) step(1'b1, 32'(i));
        check("t2_overflow", overflow, 1'b1);
        check("t2_level", level, 4'd8);
        hold = 0; acc_dly = 0; busy_len = 5;
        idle_steps(150);
        check("t2_sent_count", n_sent - base, 8);
        check("t2_last_din", last_din, 32'h8);

        // write into a full queue on the pop cycle
        do_reset();
        hold = 1; base = n_sent;
        for (int i = 1; i <= 8; i++) step(1'b1, 32'h10 + 32'(i));
        hold = 0; acc_dly = 1; busy_len = 3; wr_on_pop = 1;
        idle_steps(100);
        check("t3_overflow", overflow, 1'b0);
        check("t3_sent_count", n_sent - base, 9);
        check("t3_last_din", last_din, 32'hA);

        // reset while busy with entries queued
        do_reset();
        acc_dly = 0; busy_len = 100;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(i));
        idle_steps(10);
        check("t4_busy_level", level, 4'd3);
        do_reset();
        idle_steps(20);
        step(1'b1, 32'h77);
        idle_steps(5);
        check("t4_new_din", last_din, 32'h77);

        // back-to-back gap
        do_reset();
        acc_dly = 0; busy_len = 50;
        step(1'b1, 32'h51);
        step(1'b1, 32'h52);
        idle_steps(60);
        check("t5_gap", gap, 1);
        idle_steps(70);
        check("t5_din2", last_din, 32'h52);

`ifdef CAN_TXQ_TIMEOUT_EN
        // controller never accepts: both entries time out
        do_reset();
        acc_dly = 1000; base = n_sent;
        step(1'b1, 32'h61);
        step(1'b1, 32'h62);
        idle_steps(60);
        check("t6_terr_count", n_terr, 2);
        check("t6_sent_count", n_sent - base, 0);
        check("t6_level", level, 4'd0);
`endif

        // randomized traffic
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            int wp;
            acc_dly  = $urandom_range(0, 4);
            busy_len = $urandom_range(0, 25);
            wp       = $urandom_range(5, 60);
            for (int i = 0; i < 300; i++) begin
                if (c_phase == 0 && $urandom_range(0, 39) == 0) hold = !hold;
                step($urandom_range(0, 99) < wp, $urandom);
            end
        end
        hold = 0; acc_dly = 0; busy_len = 2;
        idle_steps(100);
        check("rand_drained", empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
